// File: rtl/instruction_fetch_unit_pkg.sv
// Shared instruction-set definitions: opcodes, field positions, NOP word, fetch defaults.
package instruction_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned INSTR_W_DEF = 28;
  localparam int unsigned OPC_W       = 4;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 16'd0;

  localparam int unsigned OPC_HI = 27;
  localparam int unsigned OPC_LO = 24;
  localparam int unsigned F1_HI  = 23;
  localparam int unsigned F1_LO  = 16;
  localparam int unsigned F2_HI  = 15;
  localparam int unsigned F2_LO  = 8;
  localparam int unsigned F3_HI  = 7;
  localparam int unsigned F3_LO  = 0;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP = 4'h0,
    OPC_JMP = 4'h1,
    OPC_BLE = 4'h2,
    OPC_ADD = 4'h3,
    OPC_SUB = 4'h4,
    OPC_LD  = 4'h5,
    OPC_ST  = 4'h6
  } opcode_e;

  typedef enum logic [7:0] {
    REG_R0 = 8'd0,
    REG_R1 = 8'd1,
    REG_R2 = 8'd2,
    REG_R3 = 8'd3
  } reg_e;

  localparam logic [INSTR_W_DEF-1:0] NOP_WORD = {OPC_NOP, 24'd0};

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W_DEF-1:0] w);
    return w[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_pc_next.sv
// Next-PC select: redirect > (predecoded JMP target) > PC+1 > hold.
// FETCH_PREDECODE_EN enables early resolution of unconditional jumps.
module fetch_pc_next
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic               adv,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [ADDR_W-1:0]  pc_next_c
);

`ifdef FETCH_PREDECODE_EN
  logic is_jmp_c;
  assign is_jmp_c = (rom_data[INSTR_W-1 -: OPC_W] == OPC_JMP);
`else
  logic unused_rom_c;
  assign unused_rom_c = ^rom_data;
`endif

  always_comb begin
    pc_next_c = pc;
    if (branch_taken) begin
      pc_next_c = branch_target;
    end else if (adv) begin
      pc_next_c = pc + ADDR_W'(1);
`ifdef FETCH_PREDECODE_EN
      if (is_jmp_c) pc_next_c = ADDR_W'(rom_data[INSTR_W-5 -: 8]);
`endif
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, registers the ROM word, valid/ready handoff, redirect flush.
// FETCH_PREDECODE_EN (optional) lets JMP redirect the PC at fetch with no bubble.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oROMAddress,
  input  logic [INSTR_W-1:0] iROMData,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oInstrPC,
  output logic               oValid,
  input  logic               iReady,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget
);

  localparam logic [INSTR_W-1:0] NopWord = {OPC_NOP, {(INSTR_W-OPC_W){1'b0}}};

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               adv_c;

  // FILL always advances; RUN advances only when the consumer takes the word
  assign adv_c = (state_q == ST_FILL) | iReady;

  fetch_pc_next #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_pc_next (
    .pc           (pc_q),
    .adv          (adv_c),
    .branch_taken (iBranchTaken),
    .branch_target(iBranchTarget),
    .rom_data     (iROMData),
    .pc_next_c    (pc_d)
  );

  // Redirect flushes the instruction register to a NOP bubble ahead of any advance
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (iBranchTaken) begin
      state_d = ST_FILL;
      instr_d = NopWord;
    end else if (adv_c) begin
      state_d    = ST_RUN;
      instr_d    = iROMData;
      instr_pc_d = pc_q;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_FILL;
      pc_q       <= RESET_PC;
      instr_q    <= NopWord;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign oROMAddress  = pc_q;
  assign oInstruction = instr_q;
  assign oInstrPC     = instr_pc_q;
  assign oValid       = (state_q == ST_RUN);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small behavioural ROM.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        Clock;
  logic        Reset;
  logic [15:0] oROMAddress;
  logic [27:0] iROMData;
  logic [27:0] oInstruction;
  logic [15:0] oInstrPC;
  logic        oValid;
  logic        iReady;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;

  logic [27:0] rom_mem [0:15];
  int n_cmp;
  int n_err;

  localparam logic [27:0] NOP_W = 28'h0000000;

  instruction_fetch_unit dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oROMAddress  (oROMAddress),
    .iROMData     (iROMData),
    .oInstruction (oInstruction),
    .oInstrPC     (oInstrPC),
    .oValid       (oValid),
    .iReady       (iReady),
    .iBranchTaken (iBranchTaken),
    .iBranchTarget(iBranchTarget)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [27:0] rom_word(input logic [15:0] a);
    if (a < 16'd16) return rom_mem[a[3:0]];
    return {4'h3, 8'hA5, a};
  endfunction

  always_comb iROMData = rom_word(oROMAddress);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_fetch(input string tag, input logic [15:0] pc);
    check({tag, "_valid"}, 32'(oValid), 32'd1);
    check({tag, "_pc"}, 32'(oInstrPC), 32'(pc));
    check({tag, "_instr"}, 32'(oInstruction), 32'(rom_word(pc)));
  endtask

  task automatic expect_bubble(input string tag, input logic [15:0] next_pc);
    check({tag, "_valid"}, 32'(oValid), 32'd0);
    check({tag, "_instr"}, 32'(oInstruction), 32'(NOP_W));
    check({tag, "_addr"}, 32'(oROMAddress), 32'(next_pc));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) rom_mem[i] = {4'h2, 8'(i), 16'(i * 3)};
    Reset = 1'b0;
    iReady = 1'b1;
    iBranchTaken = 1'b0;
    iBranchTarget = 16'd0;

    #12;
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_instr", 32'(oInstruction), 32'(NOP_W));
    check("rst_ipc", 32'(oInstrPC), 32'd0);
    check("rst_addr", 32'(oROMAddress), 32'd0);

    // Streaming from reset
    @(negedge Clock) Reset = 1'b1;
    step(); expect_fetch("s0", 16'd0);
    step(); expect_fetch("s1", 16'd1);
    step(); expect_fetch("s2", 16'd2);

    // Stall at PC 2
    iReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_fetch("stall", 16'd2);
      check("stall_addr", 32'(oROMAddress), 32'd3);
    end
    iReady = 1'b1;
    step(); expect_fetch("res3", 16'd3);
    step(); expect_fetch("res4", 16'd4);

    // Redirect to 8 while streaming
    iBranchTaken = 1'b1; iBranchTarget = 16'd8;
    step(); expect_bubble("br8", 16'd8);
    iBranchTaken = 1'b0;
    step(); expect_fetch("t8", 16'd8);
    step(); expect_fetch("t9", 16'd9);

    // Redirect while stalled
    iReady = 1'b0; iBranchTaken = 1'b1; iBranchTarget = 16'd12;
    step(); expect_bubble("brst", 16'd12);
    iBranchTaken = 1'b0;
    step(); expect_fetch("t12", 16'd12);
    step(); expect_fetch("t12h", 16'd12);
    iReady = 1'b1;

    // Back-to-back redirects: last one wins
    iBranchTaken = 1'b1; iBranchTarget = 16'd5;
    step(); expect_bubble("bb5", 16'd5);
    iBranchTarget = 16'd9;
    step(); expect_bubble("bb9", 16'd9);
    iBranchTaken = 1'b0;
    step(); expect_fetch("bbt9", 16'd9);
    step(); expect_fetch("bbt10", 16'd10);

    // PC wrap
    iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
    step(); expect_bubble("wbr", 16'hFFFF);
    iBranchTaken = 1'b0;
    step(); expect_fetch("wffff", 16'hFFFF);
    step(); expect_fetch("w0000", 16'h0000);

    // Asynchronous reset between edges
    #2 Reset = 1'b0;
    #1;
    check("arst_valid", 32'(oValid), 32'd0);
    check("arst_instr", 32'(oInstruction), 32'(NOP_W));
    check("arst_ipc", 32'(oInstrPC), 32'd0);
    check("arst_addr", 32'(oROMAddress), 32'd0);
    @(negedge Clock) Reset = 1'b1;
    step(); expect_fetch("ar0", 16'd0);
    step(); expect_fetch("ar1", 16'd1);

    // JMP at ROM[1]
    Reset = 1'b0;
    rom_mem[1] = {4'h1, 8'd6, 16'h0000};
    @(negedge Clock) Reset = 1'b1;
    step(); expect_fetch("j0", 16'd0);
    step(); expect_fetch("j1", 16'd1);
`ifdef FETCH_PREDECODE_EN
    step(); expect_fetch("j6", 16'd6);
    step(); expect_fetch("j7", 16'd7);
`else
    step(); expect_fetch("j2", 16'd2);
    iBranchTaken = 1'b1; iBranchTarget = 16'd6;
    step(); expect_bubble("jbr", 16'd6);
    iBranchTaken = 1'b0;
    step(); expect_fetch("j6", 16'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
